// File: rtl/riscv_icache_pkg.sv
// ---------------------------------------------------------------------------
// riscv_icache_pkg
//   Shared constants and types for the instruction-cache refill path.
//   - refill_state_e : 2-bit refill FSM encoding.
//   - REFILL_BEATS   : default number of bus beats per cache line.
//   - BEAT_OFF_W     : width of the byte offset appended to a block address.
//   - BEAT_SHIFT     : log2 of the bytes per beat (beat index -> byte offset).
// ---------------------------------------------------------------------------
package riscv_icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } refill_state_e;

  localparam int unsigned REFILL_BEATS = 4;
  localparam int unsigned BEAT_OFF_W   = 4;
  localparam int unsigned BEAT_SHIFT   = 2;

endpackage : riscv_icache_pkg

// File: rtl/riscv_icache_refill.sv
// ---------------------------------------------------------------------------
// riscv_icache_refill
//   Fetches one cache line from memory as BEATS sequential bus beats and
//   hands the assembled line to the icache with a one-cycle ready pulse.
//
// Ports
//   i_riscv_refill_clk        : clock, rising edge
//   i_riscv_refill_rst        : asynchronous reset, active low
//   i_riscv_refill_rden       : line read request from the icache FSM
//   i_riscv_refill_block_addr : {tag,index} block address
//   o_riscv_refill_data_out   : assembled line (beat 0 in the low bits)
//   o_riscv_refill_ready      : line-complete pulse
//   o_riscv_refill_bus_req    : beat read request to memory
//   o_riscv_refill_bus_addr   : beat byte address {block_addr, beat*4}
//   i_riscv_refill_bus_gnt    : memory accepted the beat request
//   i_riscv_refill_bus_rvalid : beat read data valid
//   i_riscv_refill_bus_rdata  : beat read data
// ---------------------------------------------------------------------------
module riscv_icache_refill
  import riscv_icache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned S_ADDR     = 23,
  parameter int unsigned BEATS      = DATA_WIDTH / BUS_WIDTH
) (
  input  logic                         i_riscv_refill_clk,
  input  logic                         i_riscv_refill_rst,
  input  logic                         i_riscv_refill_rden,
  input  logic [S_ADDR-1:0]            i_riscv_refill_block_addr,
  output logic [DATA_WIDTH-1:0]        o_riscv_refill_data_out,
  output logic                         o_riscv_refill_ready,
  output logic                         o_riscv_refill_bus_req,
  output logic [S_ADDR+BEAT_OFF_W-1:0] o_riscv_refill_bus_addr,
  input  logic                         i_riscv_refill_bus_gnt,
  input  logic                         i_riscv_refill_bus_rvalid,
  input  logic [BUS_WIDTH-1:0]         i_riscv_refill_bus_rdata
);

  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  refill_state_e         state_q, state_d;
  logic [S_ADDR-1:0]     addr_q,  addr_d;
  logic [BEAT_W-1:0]     beat_q,  beat_d;
  logic [DATA_WIDTH-1:0] line_q,  line_d;
  // Set for the IDLE cycle right after DONE: the icache has not yet presented
  // its next block address, so a still-high rden must not be sampled there.
  logic                  skip_q,  skip_d;

  logic [BEAT_OFF_W-1:0] beat_off;

  assign beat_off = BEAT_OFF_W'(beat_q) << BEAT_SHIFT;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d                 = state_q;
    addr_d                  = addr_q;
    beat_d                  = beat_q;
    line_d                  = line_q;
    skip_d                  = 1'b0;
    o_riscv_refill_ready    = 1'b0;
    o_riscv_refill_bus_req  = 1'b0;
    o_riscv_refill_bus_addr = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_riscv_refill_rden && !skip_q) begin
          addr_d  = i_riscv_refill_block_addr;
          beat_d  = '0;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        o_riscv_refill_bus_req  = 1'b1;
        o_riscv_refill_bus_addr = {addr_q, beat_off};
        if (i_riscv_refill_bus_gnt) begin
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        o_riscv_refill_bus_addr = {addr_q, beat_off};
        if (i_riscv_refill_bus_rvalid) begin
          line_d[beat_q*BUS_WIDTH +: BUS_WIDTH] = i_riscv_refill_bus_rdata;
          if (beat_q == LAST_BEAT) begin
            state_d = ST_DONE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = ST_REQ;
          end
        end
      end

      ST_DONE: begin
        o_riscv_refill_ready = 1'b1;
        skip_d               = 1'b1;
        state_d              = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of its peers, independent of process ordering.
  always_ff @(posedge i_riscv_refill_clk or negedge i_riscv_refill_rst) begin
    if (!i_riscv_refill_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      // NOTE: the line register is wide but still reset, because the icache
      // must see an all-zero line after reset rather than stale contents.
      line_q  <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      skip_q  <= skip_d;
    end
  end

  assign o_riscv_refill_data_out = line_q;

endmodule : riscv_icache_refill

// File: tb/tb_riscv_icache_refill.sv
module tb_riscv_icache_refill;

  localparam int DW = 128;
  localparam int BW = 32;
  localparam int SA = 23;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rden = 1'b0;
  logic [SA-1:0]   block_addr = '0;
  logic            gnt = 1'b0;
  logic            rvalid = 1'b0;
  logic [BW-1:0]   rdata = '0;
  logic [DW-1:0]   data_out;
  logic            ready;
  logic            bus_req;
  logic [SA+3:0]   bus_addr;

  always #5 clk = ~clk;

  riscv_icache_refill dut (
    .i_riscv_refill_clk        (clk),
    .i_riscv_refill_rst        (rst_n),
    .i_riscv_refill_rden       (rden),
    .i_riscv_refill_block_addr (block_addr),
    .o_riscv_refill_data_out   (data_out),
    .o_riscv_refill_ready      (ready),
    .o_riscv_refill_bus_req    (bus_req),
    .o_riscv_refill_bus_addr   (bus_addr),
    .i_riscv_refill_bus_gnt    (gnt),
    .i_riscv_refill_bus_rvalid (rvalid),
    .i_riscv_refill_bus_rdata  (rdata)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [SA+3:0] addr;
    logic [BW-1:0] data;
  } beat_t;

  beat_t         beat_q[$];
  logic [DW-1:0] line_q[$];
  int            lat_q[$];

  // Memory responder configuration.
  bit mem_en  = 1'b1;
  bit stray   = 1'b0;
  int gnt_dly = 0;
  int rv_dly  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // Expected beats (address + data to return) and the resulting line.
  task automatic push_refill(input logic [SA+3:0] addr0, input logic [DW-1:0] line, input int lat);
    for (int k = 0; k < 4; k++) begin
      beat_q.push_back('{addr: addr0 + 27'(4 * k), data: line[32*k +: 32]});
    end
    line_q.push_back(line);
    lat_q.push_back(lat);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while ((line_q.size() != 0 || beat_q.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (line_q.size() != 0 || beat_q.size() != 0) begin
      fail_now("timeout waiting for refill");
      beat_q.delete();
      line_q.delete();
      lat_q.delete();
    end
  endtask

  task automatic idle_checks(input logic [DW-1:0] line);
    repeat (3) @(negedge clk);
    check("data_out held", data_out, line);
    check("idle bus_req/ready", {bus_req, ready}, 2'b00);
    check("idle bus_addr", bus_addr, '0);
  endtask

  // Memory model: grants each beat request after gnt_dly extra cycles and
  // returns data rv_dly extra cycles after the grant.
  initial begin : responder
    beat_t b;
    forever begin
      @(negedge clk);
      if (mem_en) begin
        rvalid = 1'b0;
        gnt    = 1'b0;
        if (bus_req === 1'b1) begin
          if (beat_q.size() == 0) begin
            fail_now("unexpected bus_req");
          end else begin
            b = beat_q.pop_front();
            check("bus_addr", bus_addr, b.addr);
            for (int i = 0; i < gnt_dly; i++) begin
              if (stray) begin
                rvalid = 1'b1;
                rdata  = ~b.data;
              end
              @(negedge clk);
              check("bus_addr held while ungranted", {bus_req, bus_addr}, {1'b1, b.addr});
            end
            rvalid = 1'b0;
            gnt    = 1'b1;
            @(negedge clk);
            gnt = 1'b0;
            for (int i = 0; i < rv_dly; i++) begin
              check("bus_req low in RESP", bus_req, 1'b0);
              if (stray) gnt = 1'b1;
              @(negedge clk);
            end
            gnt    = 1'b0;
            rvalid = 1'b1;
            rdata  = b.data;
          end
        end
      end
    end
  end

  // Ready monitor: every ready pulse must match the next expected line.
  initial begin : ready_mon
    forever begin
      @(negedge clk);
      if (ready === 1'b1) begin
        if (line_q.size() == 0) begin
          fail_now("spurious ready");
        end else begin
          check("data_out at ready", data_out, line_q.pop_front());
          check("latency", cyc - start_cyc + 1, lat_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [SA-1:0]   addr;
    logic [SA+3:0]   addr0;
    int              gd;
    int              rd;
    bit              stray;
    logic [DW-1:0]   line;
    int              lat;
  } vec_t;

  vec_t vecs[4];

  initial begin : main
    vecs[0] = '{23'h000010, 27'h0000100, 0, 0, 1'b0,
                128'h44444444_33333333_22222222_11111111, 10};
    vecs[1] = '{23'h000123, 27'h0001230, 3, 2, 1'b0,
                128'hDEADBEEF_CAFEF00D_0BADC0DE_12345678, 30};
    vecs[2] = '{23'h7FFFFF, 27'h7FFFFF0, 2, 1, 1'b1,
                128'hA5A5A5A5_5A5A5A5A_FFFF0000_0000FFFF, 22};
    vecs[3] = '{23'h2AAAAA, 27'h2AAAAA0, 1, 0, 1'b0,
                128'h01020304_05060708_090A0B0C_0D0E0F10, 14};

    // Reset state.
    #2;
    check("reset bus_req", bus_req, 1'b0);
    check("reset ready", ready, 1'b0);
    check("reset bus_addr", bus_addr, '0);
    check("reset data_out", data_out, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("no bus_req after reset release", bus_req, 1'b0);

    // Table-driven refills; rden is dropped right after being sampled.
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      gnt_dly    = vecs[v].gd;
      rv_dly     = vecs[v].rd;
      stray      = vecs[v].stray;
      block_addr = vecs[v].addr;
      rden       = 1'b1;
      start_cyc  = cyc;
      push_refill(vecs[v].addr0, vecs[v].line, vecs[v].lat);
      @(negedge clk);
      rden = 1'b0;
      wait_done(100);
      idle_checks(vecs[v].line);
    end
    stray   = 1'b0;
    gnt_dly = 0;
    rv_dly  = 0;

    // Stray rvalid while idle must not disturb the held line.
    mem_en = 1'b0;
    @(negedge clk);
    rvalid = 1'b1;
    rdata  = 32'hBAD0BAD0;
    repeat (3) @(negedge clk);
    check("stray rvalid in IDLE", {bus_req, data_out}, {1'b0, vecs[3].line});
    rvalid = 1'b0;
    mem_en = 1'b1;

    // Misaligned pair: rden held, address moves on right after the first ready.
    @(negedge clk);
    block_addr = 23'h000020;
    rden       = 1'b1;
    start_cyc  = cyc;
    push_refill(27'h0000200, 128'h2003_2002_2001_2000_0000_0000_0000_0000, 10);
    push_refill(27'h0000210, 128'h2113_2112_2111_2110_0000_0000_0000_0000, 21);
    repeat (9) @(negedge clk);
    block_addr = 23'h000021;
    repeat (11) @(negedge clk);
    rden = 1'b0;
    wait_done(60);
    idle_checks(128'h2113_2112_2111_2110_0000_0000_0000_0000);

    // Reset during beat 2 RESP, with beats driven by hand.
    mem_en = 1'b0;
    gnt    = 1'b0;
    rvalid = 1'b0;
    @(negedge clk);
    block_addr = 23'h000040;
    rden       = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rvalid = 1'b0;
      check("hand beat request", {bus_req, bus_addr}, {1'b1, 27'h0000400 + 27'(4 * k)});
      gnt = 1'b1;
      @(negedge clk);
      gnt    = 1'b0;
      rvalid = 1'b1;
      rdata  = 32'hA0A00000 + 32'(k);
    end
    @(negedge clk);
    rvalid = 1'b0;
    check("hand beat 2 request", {bus_req, bus_addr}, {1'b1, 27'h0000408});
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("mid-refill reset outputs", {bus_req, ready, bus_addr}, '0);
    check("mid-refill reset data_out", data_out, '0);
    @(negedge clk);
    rst_n     = 1'b1;
    start_cyc = cyc;
    push_refill(27'h0000400, 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0, 10);
    mem_en = 1'b1;
    #1;
    check("no bus_req in first cycle after reset", bus_req, 1'b0);
    @(negedge clk);
    rden = 1'b0;
    wait_done(100);
    idle_checks(128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_riscv_icache_refill
